// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one pipelined ALU between two issue slots
module alu_issue_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [5:0]       req0_funct,
  input  logic [1:0]       req0_aluop,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [5:0]       req1_funct,
  input  logic [1:0]       req1_aluop,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       flush,
  output logic             alu_valid,
  output logic [5:0]       alu_funct,
  output logic [1:0]       alu_aluop,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic             w_any;
  logic             w_sel;
  logic [LAT-1:0]   w_live;
  logic             r_rr;
  logic [LAT-1:0]   r_tag_v;
  logic [LAT-1:0]   r_tag_o;
  logic [1:0]       r_resp_v;
  logic [WIDTH-1:0] r_resp_d;
  logic             r_alu_v;
  logic [5:0]       r_alu_f;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;

  // Grant a lone eligible slot, break ties with the round-robin pointer; drop tags hit by their owner's flush
  always_comb begin
    w_elig  = req_valid & ~flush;
    w_any   = |w_elig;
    w_sel   = (&w_elig) ? r_rr : w_elig[1];
    w_grant = w_any ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    w_live  = r_tag_v & ~((r_tag_o & {LAT{flush[1]}}) | (~r_tag_o & {LAT{flush[0]}}));
  end

  // Round-robin pointer points away from the slot granted last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr <= 1'b0;
    else if (w_any) r_rr <= ~w_sel;

  // Issue stage: fields of the granted op, held when nothing is granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_alu_v  <= 1'b0;
      r_alu_f  <= '0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else begin
      r_alu_v <= w_any;
      if (w_any) begin
        r_alu_f  <= w_sel ? req1_funct : req0_funct;
        r_alu_op <= w_sel ? req1_aluop : req0_aluop;
        r_alu_a  <= w_sel ? req1_a : req0_a;
        r_alu_b  <= w_sel ? req1_b : req0_b;
      end
    end

  // Owner tags travel alongside the ALU pipeline; the last stage steers the result into the response stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_o  <= '0;
      r_resp_v <= '0;
      r_resp_d <= '0;
    end else begin
      r_tag_v  <= (w_live << 1) | LAT'(w_any);
      r_tag_o  <= (r_tag_o << 1) | LAT'(w_sel);
      r_resp_v <= w_live[LAT-1] ? (r_tag_o[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
      if (w_live[LAT-1]) r_resp_d <= alu_result;
    end

  assign req_ready  = w_grant;
  assign alu_valid  = r_alu_v;
  assign alu_funct  = r_alu_f;
  assign alu_aluop  = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign resp_valid = r_resp_v & ~flush;
  assign resp_data  = r_resp_d;
  assign busy       = (|r_tag_v) | (|r_resp_v);
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: LAT=1/2/8 arbiters on shared stimulus, checked against a per-op scoreboard
module tb_alu_issue_arbiter;
  localparam int W = 32;
  localparam int N = 4096;

  typedef struct {
    logic [1:0] rv;
    logic [1:0] fl;
    logic [1:0] rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] flush = '0;
  logic [5:0] f0 = '0, f1 = '0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] rdy [3];
  logic [1:0] rvo [3];
  logic av [3];
  logic bsy [3];
  logic [5:0] af [3];
  logic [1:0] aop [3];
  logic [W-1:0] aa [3];
  logic [W-1:0] ab [3];
  logic [W-1:0] res [3];
  logic [W-1:0] rd [3];

  int cyc_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit pref;
  bit e_av;
  logic [5:0] e_f;
  logic [1:0] e_op;
  logic [W-1:0] e_a, e_b;
  bit alive [3][N];
  bit eslot [3][N];
  logic [W-1:0] edata [3][N];
  vec_t tbl [32];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [5:0] f, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    case (f)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2a: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic int lat(input int d);
    return d == 0 ? 1 : d == 1 ? 2 : 8;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? 1 : g == 1 ? 2 : 8;
    logic [W-1:0] comb_r;
    alu_issue_arbiter #(.WIDTH(W), .LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[g]),
      .req0_funct(f0), .req0_aluop(op0), .req0_a(a0), .req0_b(b0),
      .req1_funct(f1), .req1_aluop(op1), .req1_a(a1), .req1_b(b1),
      .flush(flush), .alu_valid(av[g]), .alu_funct(af[g]), .alu_aluop(aop[g]),
      .alu_a(aa[g]), .alu_b(ab[g]), .alu_result(res[g]),
      .resp_valid(rvo[g]), .resp_data(rd[g]), .busy(bsy[g])
    );
    assign comb_r = alu_fn(af[g], aop[g], aa[g], ab[g]);
    if (L == 1) begin : g_c
      assign res[g] = comb_r;
    end else begin : g_p
      logic [W-1:0] p [L-1];
      always @(posedge clk) begin
        p[0] <= comb_r;
        for (int k = 1; k < L - 1; k++) p[k] <= p[k-1];
      end
      assign res[g] = p[L-2];
    end
  end

  task automatic chk(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d cyc=%0d got %0h want %0h", nm, lat(d), cyc_n, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < N; i++) alive[d][i] = 0;
    pref = 0;
    e_av = 0;
    e_f = '0;
    e_op = '0;
    e_a = '0;
    e_b = '0;
  endtask

  task automatic chk_zero();
    for (int d = 0; d < 3; d++) begin
      chk("rst_alu_valid", d, av[d], 0);
      chk("rst_alu_funct", d, af[d], 0);
      chk("rst_alu_a", d, aa[d], 0);
      chk("rst_resp_valid", d, rvo[d], 0);
      chk("rst_resp_data", d, rd[d], 0);
      chk("rst_busy", d, bsy[d], 0);
    end
  endtask

  task automatic step(input logic [1:0] rv, input logic [1:0] fl, input bit use_t, input logic [1:0] t_rdy);
    logic [1:0] el, g;
    logic [W-1:0] gd;
    bit s;
    req_valid = rv;
    flush = fl;
    #3;
    el = rv & ~fl;
    g = (el == 2'b11) ? (pref ? 2'b10 : 2'b01) : el;
    s = g[1];
    gd = s ? alu_fn(f1, op1, a1, b1) : alu_fn(f0, op0, a0, b0);
    for (int d = 0; d < 3; d++) begin
      int i;
      logic [1:0] er;
      bit b;
      i = cyc_n % N;
      er = (alive[d][i] && !fl[eslot[d][i]]) ? (eslot[d][i] ? 2'b10 : 2'b01) : 2'b00;
      b = 0;
      for (int k = 0; k <= lat(d); k++) b |= alive[d][(cyc_n + k) % N];
      chk("req_ready", d, rdy[d], g);
      if (use_t) chk("tbl_ready", d, rdy[d], t_rdy);
      chk("alu_valid", d, av[d], e_av);
      chk("alu_funct", d, af[d], e_f);
      chk("alu_aluop", d, aop[d], e_op);
      chk("alu_a", d, aa[d], e_a);
      chk("alu_b", d, ab[d], e_b);
      chk("resp_valid", d, rvo[d], er);
      if (er != 2'b00) chk("resp_data", d, rd[d], edata[d][i]);
      chk("busy", d, bsy[d], b);
    end
    for (int d = 0; d < 3; d++) begin
      for (int k = 1; k <= lat(d); k++) begin
        int j;
        j = (cyc_n + k) % N;
        if (alive[d][j] && fl[eslot[d][j]]) alive[d][j] = 0;
      end
      alive[d][cyc_n % N] = 0;
      if (g != 2'b00) begin
        alive[d][(cyc_n + lat(d) + 1) % N] = 1;
        eslot[d][(cyc_n + lat(d) + 1) % N] = s;
        edata[d][(cyc_n + lat(d) + 1) % N] = gd;
      end
    end
    e_av = g != 2'b00;
    if (g != 2'b00) begin
      e_f = s ? f1 : f0;
      e_op = s ? op1 : op0;
      e_a = s ? a1 : a0;
      e_b = s ? b1 : b0;
      pref = ~s;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_model();
    for (int i = 0; i < 32; i++) tbl[i] = '{2'b00, 2'b00, 2'b00};
    tbl[0]  = '{2'b01, 2'b00, 2'b01};
    tbl[4]  = '{2'b10, 2'b00, 2'b10};
    tbl[5]  = '{2'b11, 2'b00, 2'b01};
    tbl[6]  = '{2'b11, 2'b00, 2'b10};
    tbl[7]  = '{2'b11, 2'b00, 2'b01};
    tbl[8]  = '{2'b11, 2'b00, 2'b10};
    tbl[13] = '{2'b10, 2'b00, 2'b10};
    tbl[14] = '{2'b01, 2'b10, 2'b01};
    tbl[19] = '{2'b11, 2'b01, 2'b10};
    tbl[20] = '{2'b11, 2'b00, 2'b01};
    tbl[21] = '{2'b11, 2'b00, 2'b10};
    #1;
    chk_zero();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = 6'h20; op0 = 2'd2; a0 = 5; b0 = 3;
    f1 = 6'h22; op1 = 2'd2; a1 = 9; b1 = 4;
    for (int i = 0; i < 32; i++) step(tbl[i].rv, tbl[i].fl, 1'b1, tbl[i].rdy);
    step(2'b01, 2'b00, 1'b0, 2'b00);
    step(2'b10, 2'b00, 1'b0, 2'b00);
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero();
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_n++;
    repeat (12) step(2'b00, 2'b00, 1'b0, 2'b00);
    step(2'b11, 2'b00, 1'b1, 2'b01);
    for (int n = 0; n < 600; n++) begin
      logic [5:0] fl6 [7];
      fl6 = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
      f0 = fl6[$urandom_range(0, 6)];
      f1 = fl6[$urandom_range(0, 6)];
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      step(2'($urandom_range(0, 3)), {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0}, 1'b0, 2'b00);
    end
    repeat (12) step(2'b00, 2'b00, 1'b0, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
